// File: rtl/lsu_mem_stage_if.sv
// Request / memory / response bundle for lsu_mem_stage.
// slave  : the load/store unit itself (accepts requests, drives the memory port).
// master : the surrounding pipeline and data memory.
interface lsu_mem_stage_if #(
    parameter int WIDTH = 32
);
    // Request from execute
    logic             req_valid;
    logic             req_ready;
    logic             req_store;
    logic [2:0]       req_funct3;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;

    // Data-memory handshake
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [3:0]       mem_be;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;

    // Completion to writeback
    logic             resp_valid;
    logic [WIDTH-1:0] resp_rdata;
    logic             resp_err;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  mem_ack, mem_rdata,
        output req_ready,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output resp_valid, resp_rdata, resp_err
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        output mem_ack, mem_rdata,
        input  req_ready,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// Load/store unit for the memory stage: one data-memory transaction per
// request, byte-lane steering for stores, sign/zero extension for loads.
// Optional build macro LSU_MISALIGN_TRAP_EN turns misaligned halfword/word
// accesses into errors; without it the low address bits are simply ignored.
// Byte-lane logic assumes WIDTH = 32.
module lsu_mem_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    lsu_mem_stage_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             store_q, store_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [1:0]       offset_q, offset_d;

    logic             req_ready_q, req_ready_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic             resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic             resp_err_q, resp_err_d;

    logic             req_legal;
    logic [3:0]       req_be;
    logic [WIDTH-1:0] req_wdata_lane;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [WIDTH-1:0] load_data;

    // Decode the incoming request: legality, byte enables and lane-replicated store data.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        req_legal      = 1'b1;
        req_be         = 4'b1111;
        req_wdata_lane = bus.req_wdata;
        if (bus.req_store) begin
            case (bus.req_funct3)
                3'b000: begin
                    req_be         = 4'b0001 << bus.req_addr[1:0];
                    req_wdata_lane = {4{bus.req_wdata[7:0]}};
                end
                3'b001: begin
                    req_be         = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                    req_wdata_lane = {2{bus.req_wdata[15:0]}};
                end
                3'b010:  req_be    = 4'b1111;
                default: req_legal = 1'b0;
            endcase
        end else begin
            case (bus.req_funct3)
                3'b011, 3'b110, 3'b111: req_legal = 1'b0;
                default:                req_legal = 1'b1;
            endcase
        end
`ifdef LSU_MISALIGN_TRAP_EN
        if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])
            req_legal = 1'b0;
        if (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00)
            req_legal = 1'b0;
`endif
    end

    // Extract and extend the addressed lane of the returned read word.
    always_comb begin
        case (offset_q)
            2'd0:    byte_sel = bus.mem_rdata[7:0];
            2'd1:    byte_sel = bus.mem_rdata[15:8];
            2'd2:    byte_sel = bus.mem_rdata[23:16];
            default: byte_sel = bus.mem_rdata[31:24];
        endcase
        half_sel = offset_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_data = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {{(WIDTH-8){1'b0}}, byte_sel};
            3'b001:  load_data = {{(WIDTH-16){half_sel[15]}}, half_sel};
            3'b101:  load_data = {{(WIDTH-16){1'b0}}, half_sel};
            default: load_data = bus.mem_rdata;
        endcase
    end

    // FSM next-state and next-output computation; everything holds unless changed.
    always_comb begin
        state_d      = state_q;
        store_d      = store_q;
        funct3_d     = funct3_q;
        offset_d     = offset_q;
        req_ready_d  = req_ready_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (bus.req_valid) begin
                    store_d     = bus.req_store;
                    funct3_d    = bus.req_funct3;
                    offset_d    = bus.req_addr[1:0];
                    req_ready_d = 1'b0;
                    if (req_legal) begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.req_store;
                        mem_addr_d  = {bus.req_addr[WIDTH-1:2], 2'b00};
                        mem_be_d    = req_be;
                        mem_wdata_d = bus.req_store ? req_wdata_lane : '0;
                        state_d     = ACCESS;
                    end else begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                        state_d      = RESP;
                    end
                end
            end
            ACCESS: begin
                if (bus.mem_ack) begin
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = store_q ? '0 : load_data;
                    state_d      = RESP;
                end
            end
            RESP: begin
                resp_valid_d = 1'b0;
                resp_err_d   = 1'b0;
                resp_rdata_d = '0;
                req_ready_d  = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                mem_req_d    = 1'b0;
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
                state_d      = IDLE;
            end
        endcase
    end

    // State and registered outputs, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            state_q      <= IDLE;
            store_q      <= 1'b0;
            funct3_q     <= 3'b000;
            offset_q     <= 2'b00;
            req_ready_q  <= 1'b1;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= 4'b0000;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            store_q      <= store_d;
            funct3_q     <= funct3_d;
            offset_q     <= offset_d;
            req_ready_q  <= req_ready_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_be     = mem_be_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: stimulus tasks set the expected outputs
// for each cycle from an arithmetic model of the load/store rules, and a
// negedge process compares the DUT against them every cycle.
module tb_lsu_mem_stage;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;

    lsu_mem_stage_if #(.WIDTH(32)) bus ();

    lsu_mem_stage #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Expected outputs for the current cycle
    logic        exp_ready, exp_mem_req, exp_we, exp_resp_valid, exp_err;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_be;

    // Values captured from the DUT for literal checks
    logic [31:0] acc_addr, acc_wdata, last_rdata;
    logic [3:0]  acc_be;
    logic        acc_we, acc_req, last_valid, last_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // ---------------- model ----------------
    function automatic bit m_legal(bit st, logic [2:0] f3, logic [31:0] a);
        bit ok;
        if (st) ok = (f3 <= 3'd2);
        else    ok = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
`ifdef LSU_MISALIGN_TRAP_EN
        if (ok && (a % (32'd1 << f3[1:0])) != 0) ok = 1'b0;
`endif
        return ok;
    endfunction

    function automatic logic [3:0] m_be(bit st, logic [2:0] f3, logic [31:0] a);
        if (!st)        return 4'hF;
        if (f3 == 3'd0) return 4'(32'd1 << (a % 4));
        if (f3 == 3'd1) return ((a % 4) >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(bit st, logic [2:0] f3, logic [31:0] d);
        if (!st)        return 32'h0;
        if (f3 == 3'd0) return (d & 32'hFF) * 32'h01010101;
        if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a, logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * (a % 4))) & 32'hFF;
        h = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128)   ? b + 32'hFFFFFF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd5:    return h;
            default: return rd;
        endcase
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            check("req_ready", {31'd0, bus.req_ready}, {31'd0, exp_ready});
            check("mem_req", {31'd0, bus.mem_req}, {31'd0, exp_mem_req});
            check("resp_valid", {31'd0, bus.resp_valid}, {31'd0, exp_resp_valid});
            if (exp_mem_req) begin
                check("mem_we", {31'd0, bus.mem_we}, {31'd0, exp_we});
                check("mem_addr", bus.mem_addr, exp_addr);
                check("mem_be", {28'd0, bus.mem_be}, {28'd0, exp_be});
                check("mem_wdata", bus.mem_wdata, exp_wdata);
            end
            if (exp_resp_valid) begin
                check("resp_rdata", bus.resp_rdata, exp_rdata);
                check("resp_err", {31'd0, bus.resp_err}, {31'd0, exp_err});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_idle();
        exp_ready      = 1'b1;
        exp_mem_req    = 1'b0;
        exp_resp_valid = 1'b0;
    endtask

    // One full transaction; stall = ACCESS cycles without ack before the ack cycle.
    // spam drives a bogus request during the stall, which must be ignored.
    task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int stall, input logic [31:0] rd,
                          input bit spam);
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        step();
        bus.req_valid = 1'b0;
        acc_req   = bus.mem_req;
        acc_addr  = bus.mem_addr;
        acc_be    = bus.mem_be;
        acc_wdata = bus.mem_wdata;
        acc_we    = bus.mem_we;
        if (m_legal(st, f3, a)) begin
            exp_ready      = 1'b0;
            exp_mem_req    = 1'b1;
            exp_we         = st;
            exp_addr       = a & ~32'd3;
            exp_be         = m_be(st, f3, a);
            exp_wdata      = m_wdata(st, f3, wd);
            exp_resp_valid = 1'b0;
            for (int i = 0; i < stall; i++) begin
                if (spam) begin
                    bus.req_valid = 1'b1;
                    bus.req_store = ~st;
                    bus.req_addr  = 32'hFFFF_FFFC;
                end
                step();
            end
            bus.req_valid = 1'b0;
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rd;
            step();
            bus.mem_ack    = 1'b0;
            bus.mem_rdata  = 32'h5A5A_5A5A;
            exp_mem_req    = 1'b0;
            exp_resp_valid = 1'b1;
            exp_err        = 1'b0;
            exp_rdata      = st ? 32'h0 : m_load(f3, a, rd);
        end else begin
            exp_ready      = 1'b0;
            exp_mem_req    = 1'b0;
            exp_resp_valid = 1'b1;
            exp_err        = 1'b1;
            exp_rdata      = 32'h0;
        end
        last_valid = bus.resp_valid;
        last_rdata = bus.resp_rdata;
        last_err   = bus.resp_err;
        step();
        exp_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n        = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = 32'h0;
        exp_idle();
        exp_we = 1'b0; exp_err = 1'b0;
        exp_addr = 32'h0; exp_wdata = 32'h0; exp_rdata = 32'h0; exp_be = 4'h0;

        // Reset held for three cycles
        repeat (3) step();
        check("rst req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("rst resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst mem_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst mem_be", {28'd0, bus.mem_be}, 32'd0);
        check("rst mem_addr", bus.mem_addr, 32'd0);
        check("rst mem_wdata", bus.mem_wdata, 32'd0);
        check("rst resp_rdata", bus.resp_rdata, 32'd0);
        check("rst resp_err", {31'd0, bus.resp_err}, 32'd0);
        reset_n = 1'b1;
        cmp_en  = 1'b1;
        step();

        // SB at byte 3
        do_req(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 32'h0, 1'b0);
        check("sb addr", acc_addr, 32'h0000_1000);
        check("sb be", {28'd0, acc_be}, 32'h8);
        check("sb wdata", acc_wdata, 32'hA5A5_A5A5);
        check("sb we", {31'd0, acc_we}, 32'd1);
        check("sb rdata", last_rdata, 32'h0);

        // Byte / half loads of 0x80F07F12
        do_req(1'b0, 3'b000, 32'h0000_2002, 32'h0, 0, 32'h80F0_7F12, 1'b0);
        check("lb rdata", last_rdata, 32'hFFFF_FFF0);
        do_req(1'b0, 3'b100, 32'h0000_2002, 32'h0, 1, 32'h80F0_7F12, 1'b0);
        check("lbu rdata", last_rdata, 32'h0000_00F0);
        do_req(1'b0, 3'b001, 32'h0000_2002, 32'h0, 0, 32'h80F0_7F12, 1'b0);
        check("lh rdata", last_rdata, 32'hFFFF_80F0);
        do_req(1'b0, 3'b101, 32'h0000_2000, 32'h0, 0, 32'h80F0_7F12, 1'b0);
        check("lhu rdata", last_rdata, 32'h0000_7F12);
        check("lhu be", {28'd0, acc_be}, 32'hF);

        // SH upper half, SW with a short stall
        do_req(1'b1, 3'b001, 32'h0000_1002, 32'h1234_BEEF, 0, 32'h0, 1'b0);
        check("sh be", {28'd0, acc_be}, 32'hC);
        check("sh wdata", acc_wdata, 32'hBEEF_BEEF);
        do_req(1'b1, 3'b010, 32'h0000_1004, 32'hCAFE_F00D, 2, 32'h0, 1'b0);
        check("sw wdata", acc_wdata, 32'hCAFE_F00D);

        // Stalled LW with stray requests during the stall
        do_req(1'b0, 3'b010, 32'h0000_3000, 32'h0, 5, 32'hDEAD_BEEF, 1'b1);
        check("lw stall rdata", last_rdata, 32'hDEAD_BEEF);

        // Illegal funct3: load 011, store 100
        do_req(1'b0, 3'b011, 32'h0000_4000, 32'h0, 0, 32'h0, 1'b0);
        check("ill ld valid", {31'd0, last_valid}, 32'd1);
        check("ill ld err", {31'd0, last_err}, 32'd1);
        check("ill ld no mem_req", {31'd0, acc_req}, 32'd0);
        do_req(1'b1, 3'b100, 32'h0000_4000, 32'h1, 0, 32'h0, 1'b0);
        check("ill st err", {31'd0, last_err}, 32'd1);

        // mem_ack while idle is ignored
        bus.mem_ack = 1'b1;
        step();
        step();
        bus.mem_ack = 1'b0;
        step();

        // Misaligned word / half
        do_req(1'b0, 3'b010, 32'h0000_3002, 32'h0, 0, 32'h1122_3344, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis lw err", {31'd0, last_err}, 32'd1);
        check("mis lw no mem_req", {31'd0, acc_req}, 32'd0);
`else
        check("mis lw addr", acc_addr, 32'h0000_3000);
        check("mis lw rdata", last_rdata, 32'h1122_3344);
        check("mis lw err", {31'd0, last_err}, 32'd0);
`endif
        do_req(1'b0, 3'b001, 32'h0000_2003, 32'h0, 0, 32'h80F0_7F12, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis lh err", {31'd0, last_err}, 32'd1);
`else
        check("mis lh rdata", last_rdata, 32'hFFFF_80F0);
`endif

        // Reset during ACCESS, then a late ack
        bus.req_valid  = 1'b1;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h0000_5000;
        step();
        bus.req_valid  = 1'b0;
        exp_ready      = 1'b0;
        exp_mem_req    = 1'b1;
        exp_we         = 1'b0;
        exp_addr       = 32'h0000_5000;
        exp_be         = 4'hF;
        exp_wdata      = 32'h0;
        reset_n        = 1'b0;
        step();
        exp_idle();
        check("abort mem_req", {31'd0, bus.mem_req}, 32'd0);
        reset_n     = 1'b1;
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        check("abort no resp", {31'd0, bus.resp_valid}, 32'd0);
        step();
        check("abort idle ready", {31'd0, bus.req_ready}, 32'd1);

        // Normal traffic after the abort
        do_req(1'b0, 3'b000, 32'h0000_6001, 32'h0, 0, 32'h0000_7F00, 1'b0);
        check("post abort lb", last_rdata, 32'h0000_007F);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit sitting directly downstream of the ALU in the execute/memory path.
- Consumes the ALU result as the effective address, plus store data and funct3 from decode.
- Performs one data-memory transaction per request over a valid/ack memory handshake.
- Returns aligned, sign/zero-extended load data, or a store-done pulse, to writeback.

Parameters:
- WIDTH, 32, address/data width; byte-lane logic is defined for 32 only.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- req_valid  input  1  request present (address from ALU output)
- req_ready  output  1  unit can accept a request; high only in IDLE
- req_store  input  1  1 = store, 0 = load
- req_funct3  input  3  RISC-V funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- req_addr  input  WIDTH  effective byte address (ALU result)
- req_wdata  input  WIDTH  store data (rs2)
- mem_req  output  1  memory request, held until mem_ack
- mem_we  output  1  write enable
- mem_addr  output  WIDTH  word address, {req_addr[WIDTH-1:2], 2'b00}
- mem_be  output  4  byte enables
- mem_wdata  output  WIDTH  lane-shifted store data
- mem_ack  input  1  memory accepted write / rdata valid this cycle
- mem_rdata  input  WIDTH  read word
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  WIDTH  extended load data; 0 for stores and errors
- resp_err  output  1  request failed, no memory access (qualified by resp_valid)

Behaviour:
- Clock and reset:
  - Single clock; reset is synchronous and active-low.
  - Reset values: state IDLE; req_ready 1; mem_req 0; mem_we 0; mem_be 0; mem_addr 0; mem_wdata 0; resp_valid 0; resp_rdata 0; resp_err 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch store, funct3, addr and wdata; compute be/wdata.
  - If the request is legal, go to ACCESS; otherwise go to RESP with err=1.
- ACCESS:
  - mem_req=1; mem_we, mem_addr, mem_be and mem_wdata are held stable.
  - On mem_ack: capture the extended load data (0 for stores), then go to RESP.
  - Stalls indefinitely without mem_ack.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - req_ready=0, so a new request is accepted no earlier than the cycle after RESP.
- Latency:
  - Request accepted at edge N; mem_req high in cycle N+1.
  - With ack in that same cycle, resp_valid is high in cycle N+2.
  - Error path: resp_valid in cycle N+1.
- Store lanes (k = addr[1:0]):
  - SB: be = 4'b0001<<k; wdata = byte replicated in all 4 lanes.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = halfword replicated.
  - SW: be = 4'b1111.
- Load extraction:
  - LB/LBU: byte lane k, sign-extended (LB) or zero-extended (LBU).
  - LH/LHU: half lane addr[1], sign-extended or zero-extended.
  - LW: full word.
  - Loads drive mem_be = 4'b1111.
- Illegal funct3: store funct3 outside {000,001,010}, or load funct3 in {011,110,111} → err, no memory access.
- Edge cases:
  - mem_ack outside ACCESS is ignored.
  - req_valid outside IDLE is ignored (req_ready=0).
  - Reset asserted mid-ACCESS: the next edge returns to IDLE and drops mem_req; no resp_valid is produced for the aborted request; a late mem_ack is ignored.
- Address wrap: none; mem_addr is the truncated word address.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Halfword access with addr[0]=1 is an error.
  - Word access with addr[1:0]!=0 is an error.
  - Errors skip memory and produce resp_valid with resp_err=1 and resp_rdata=0.
- Undefined:
  - Misalignment is never an error.
  - Halfword ignores addr[0]; word ignores addr[1:0]; the access proceeds normally.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles → req_ready=1, mem_req=0, resp_valid=0.
- SB, addr=0x1003, wdata=0x000000A5 → mem_addr=0x1000, mem_be=4'b1000, mem_wdata=0xA5A5A5A5, mem_we=1. Ack in the first ACCESS cycle → resp_valid two cycles after accept, resp_rdata=0.
- LB / LBU / LH, mem_rdata=0x80F07F12:
  - LB addr=0x2002 → 0xFFFFFFF0.
  - LBU addr=0x2002 → 0x000000F0.
  - LH addr=0x2002 → 0xFFFF80F0.
- Memory stall: LW addr=0x3000, mem_ack withheld 5 cycles → mem_req and mem_addr stay stable, req_ready=0. Ack with 0xDEADBEEF → resp_rdata=0xDEADBEEF.
- Illegal funct3: load funct3=3'b011 → no mem_req, resp_valid next cycle, resp_err=1.
- Abort and misalignment:
  - reset_n=0 during ACCESS, then mem_ack → no resp_valid, state IDLE.
  - With macro: LW addr=0x3002 → resp_err=1, no mem_req.
  - Without macro: LW addr=0x3002 → mem_addr=0x3000, normal completion.
